fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of the instruction memory. Generates the byte-address program counter and drives the memory read port. Captures the combinationally returned 32-bit instruction into a 2-entry queue and presents it to decode with a valid/ready handshake. Also handles control-flow redirects from execute and a halt request.

---
 rtl/fetch_queue.sv | 195 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding decode.
//   Generates the byte-address PC, drives the instruction memory read port,
//   captures the combinationally returned word into a 2-entry FIFO and
//   presents the head to decode with a valid/ready handshake. Handles
//   redirects from execute and a halt request.
// Ports:
//   clock, reset          : rising-edge clock, async active-low reset
//   readEnable/readAddress: memory read port (readData returns same cycle)
//   inst_o/inst_pc_o      : head instruction and its PC
//   inst_valid_o/ready_i  : decode handshake
//   redirect_i/pc_i       : one-cycle flush and restart at a new PC
//   halt_i/halted_o       : stop issuing fetches / HALT state indicator
//   fetch_count_o         : instructions delivered to decode (wraps)
module fetch_queue #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic                  halted_o,
  output logic [31:0]           fetch_count_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_e                  state_q;
  logic                    halted_q;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [1:0]              count_q, count_d;
  logic [DATA_WIDTH-1:0]   head_inst_q, head_inst_d, tail_inst_q, tail_inst_d;
  logic [ADDR_WIDTH-1:0]   head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [31:0]             fetch_count_q, fetch_count_d;

  logic redirect_s;
  logic pop_s;
  logic push_s;
  logic unused_s;

  // Low PC bits of the redirect target are always forced to zero.
  assign unused_s = ^redirect_pc_i[1:0];

  // BOOT ignores redirect; the queue is empty there anyway.
  assign redirect_s   = redirect_i && (state_q != ST_BOOT);
  assign inst_valid_o = (count_q != 2'd0) && !redirect_s;
  assign pop_s        = inst_valid_o && inst_ready_i;
  // A full queue still accepts a fetch when its head leaves this cycle.
  assign push_s       = (state_q == ST_RUN) && !redirect_i &&
                        ((count_q != 2'd2) || pop_s);

  assign readEnable    = push_s;
  assign readAddress   = pc_q;
  assign inst_o        = head_inst_q;
  assign inst_pc_o     = head_pc_q;
  assign halted_o      = halted_q;
  assign fetch_count_o = fetch_count_q;

  // Next-state for PC, queue storage and delivery counter.
  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    head_inst_d   = head_inst_q;
    head_pc_d     = head_pc_q;
    tail_inst_d   = tail_inst_q;
    tail_pc_d     = tail_pc_q;
    fetch_count_d = fetch_count_q;
    if (pop_s) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (redirect_s) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    end else begin
      if (push_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      case ({push_s, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_inst_d = readData;
            head_pc_d   = pc_q;
          end else begin
            tail_inst_d = readData;
            tail_pc_d   = pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Emptying pop leaves the old head visible (valid drops).
          if (count_q == 2'd2) begin
            head_inst_d = tail_inst_q;
            head_pc_d   = tail_pc_q;
          end else begin
            head_inst_d = head_inst_q;
            head_pc_d   = head_pc_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_inst_d = tail_inst_q;
            head_pc_d   = tail_pc_q;
            tail_inst_d = readData;
            tail_pc_d   = pc_q;
          end else begin
            head_inst_d = readData;
            head_pc_d   = pc_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Control FSM: BOOT -> RUN, RUN <-> HALT; redirect beats halt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
        ST_RUN: begin
          if (!redirect_i && halt_i) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        ST_HALT: begin
          if (redirect_i) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      count_q       <= 2'd0;
      head_inst_q   <= '0;
      head_pc_q     <= '0;
      tail_inst_q   <= '0;
      tail_pc_q     <= '0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      head_inst_q   <= head_inst_d;
      head_pc_q     <= head_pc_d;
      tail_inst_q   <= tail_inst_d;
      tail_pc_q     <= tail_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected deliveries;
// a negedge monitor compares every decode handshake against the scoreboard.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        readEnable;
  logic [11:0] readAddress;
  logic [31:0] readData;
  logic [31:0] inst_o;
  logic [11:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        redirect_i;
  logic [11:0] redirect_pc_i;
  logic        halt_i;
  logic        halted_o;
  logic [31:0] fetch_count_o;

  typedef struct packed {
    logic [11:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  assign readData = mem[readAddress[11:2]];

  fetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .RESET_PC(12'h000)) dut (
    .clock(clock), .reset(reset), .readEnable(readEnable),
    .readAddress(readAddress), .readData(readData), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .halt_i(halt_i), .halted_o(halted_o),
    .fetch_count_o(fetch_count_o)
  );

  function automatic logic [31:0] word_at(input logic [11:0] pc);
    case (pc)
      12'h000: word_at = 32'h0000_0013;
      12'h004: word_at = 32'h0010_0093;
      12'h008: word_at = 32'h0020_0113;
      default: word_at = 32'hA000_0000 | {20'd0, pc};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [11:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = word_at(pc);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  {31'd0, readEnable}, 32'd0);
    check({tag, "_rd_addr"}, {20'd0, readAddress}, 32'd0);
    check({tag, "_valid"},  {31'd0, inst_valid_o}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted_o}, 32'd0);
    check({tag, "_count"},  fetch_count_o, 32'd0);
    check({tag, "_inst"},   inst_o, 32'd0);
    check({tag, "_inst_pc"}, {20'd0, inst_pc_o}, 32'd0);
  endtask

  // Monitor: each handshake seen mid-cycle must match the scoreboard head.
  always @(negedge clock) begin
    if (inst_valid_o && inst_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc 0x%03h with no expected entry", inst_pc_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("deliver_pc", {20'd0, inst_pc_o}, {20'd0, e.pc});
        check("deliver_inst", inst_o, e.inst);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = word_at(12'(i * 4));
    reset = 1'b0; inst_ready_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 12'h000; halt_i = 1'b0;
    #2;
    check_reset_outputs("reset");

    // Boot: release between edges, BOOT cycle issues no fetch.
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1; inst_ready_i = 1'b1;
    expect_pc(12'h000); expect_pc(12'h004); expect_pc(12'h008);
    #1;
    check("boot_rd_en", {31'd0, readEnable}, 32'd0);
    tick();  // E0
    check("first_fetch_en", {31'd0, readEnable}, 32'd1);
    check("first_fetch_addr", {20'd0, readAddress}, 32'h000);
    check("e0_valid", {31'd0, inst_valid_o}, 32'd0);
    tick();  // E1
    check("e1_valid", {31'd0, inst_valid_o}, 32'd1);
    check("e1_pc", {20'd0, inst_pc_o}, 32'h000);
    tick(); tick(); tick();
    inst_ready_i = 1'b0;
    check("boot_fetch_count", fetch_count_o, 32'd3);

    // Restart at 0 and apply backpressure for 5 cycles.
    redirect_i = 1'b1; redirect_pc_i = 12'h000;
    #1;
    check("redir0_valid", {31'd0, inst_valid_o}, 32'd0);
    check("redir0_rd_en", {31'd0, readEnable}, 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    check("bp_fetch0_addr", {20'd0, readAddress}, 32'h000);
    check("bp_fetch0_en", {31'd0, readEnable}, 32'd1);
    tick();
    check("bp_fetch4_addr", {20'd0, readAddress}, 32'h004);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_full_rd_en", {31'd0, readEnable}, 32'd0);
      check("bp_full_addr", {20'd0, readAddress}, 32'h008);
    end
    expect_pc(12'h000); expect_pc(12'h004); expect_pc(12'h008);
    inst_ready_i = 1'b1;
    #1;
    check("bp_resume_en", {31'd0, readEnable}, 32'd1);
    check("bp_resume_addr", {20'd0, readAddress}, 32'h008);
    tick(); tick(); tick();
    inst_ready_i = 1'b0;
    #1;
    check("bp_fetch_count", fetch_count_o, 32'd6);
    check("full_rd_en", {31'd0, readEnable}, 32'd0);

    // Redirect with a full queue; ready high must not transfer.
    redirect_i = 1'b1; redirect_pc_i = 12'h103; inst_ready_i = 1'b1;
    #1;
    check("redir_full_valid", {31'd0, inst_valid_o}, 32'd0);
    check("redir_full_rd_en", {31'd0, readEnable}, 32'd0);
    tick();
    redirect_i = 1'b0; inst_ready_i = 1'b0;
    #1;
    check("redir_count_hold", fetch_count_o, 32'd6);
    check("redir_target_addr", {20'd0, readAddress}, 32'h100);
    check("redir_target_en", {31'd0, readEnable}, 32'd1);
    expect_pc(12'h100); expect_pc(12'h104);
    tick();
    check("redir_valid", {31'd0, inst_valid_o}, 32'd1);
    check("redir_valid_pc", {20'd0, inst_pc_o}, 32'h100);

    // Halt with one entry queued: same-cycle fetch still happens.
    halt_i = 1'b1;
    #1;
    check("halt_cycle_en", {31'd0, readEnable}, 32'd1);
    check("halt_cycle_addr", {20'd0, readAddress}, 32'h104);
    tick();
    halt_i = 1'b0;
    check("halted_set", {31'd0, halted_o}, 32'd1);
    check("halted_no_fetch", {31'd0, readEnable}, 32'd0);
    inst_ready_i = 1'b1;
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      check("halt_idle_valid", {31'd0, inst_valid_o}, 32'd0);
      check("halt_idle_rd_en", {31'd0, readEnable}, 32'd0);
    end
    check("halt_fetch_count", fetch_count_o, 32'd8);

    // Leave HALT via redirect to 0x040.
    redirect_i = 1'b1; redirect_pc_i = 12'h040;
    expect_pc(12'h040);
    tick();
    redirect_i = 1'b0;
    #1;
    check("unhalt_halted", {31'd0, halted_o}, 32'd0);
    check("unhalt_addr", {20'd0, readAddress}, 32'h040);
    check("unhalt_en", {31'd0, readEnable}, 32'd1);
    tick(); tick();

    // Wrap across the top of the address space.
    redirect_i = 1'b1; redirect_pc_i = 12'hFF8;
    expect_pc(12'hFF8); expect_pc(12'hFFC); expect_pc(12'h000); expect_pc(12'h004);
    tick();
    redirect_i = 1'b0;
    #1;
    check("wrap_first_addr", {20'd0, readAddress}, 32'hFF8);
    tick(); tick(); tick(); tick(); tick();
    inst_ready_i = 1'b0;
    check("wrap_fetch_count", fetch_count_o, 32'd13);
    tick();
    check("prereset_full_valid", {31'd0, inst_valid_o}, 32'd1);
    check("prereset_head_pc", {20'd0, inst_pc_o}, 32'h008);
    check("prereset_rd_en", {31'd0, readEnable}, 32'd0);

    // Async reset between edges with a full queue.
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    #1;
    reset = 1'b1; inst_ready_i = 1'b1;
    expect_pc(12'h000);
    #1;
    check("reboot_rd_en", {31'd0, readEnable}, 32'd0);
    tick();
    check("reboot_fetch_en", {31'd0, readEnable}, 32'd1);
    check("reboot_fetch_addr", {20'd0, readAddress}, 32'h000);
    tick();
    check("reboot_valid_pc", {20'd0, inst_pc_o}, 32'h000);
    tick();
    inst_ready_i = 1'b0;
    tick();
    check("reboot_fetch_count", fetch_count_o, 32'd1);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
